// File: rtl/multi_issue_dispatcher_pkg.sv
// rtl/multi_issue_dispatcher_pkg.sv - shared state type and width helpers for the dispatcher
package md_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  // Never returns 0 so degenerate parameters still yield legal vectors.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

  function automatic int qid_w(input int number_of_queues);
    return clog2_min1(number_of_queues);
  endfunction

  function automatic int cnt_w(input int max_outstanding);
    return clog2_min1(max_outstanding + 1);
  endfunction

endpackage

// File: rtl/multi_issue_dispatcher_if.sv
// rtl/multi_issue_dispatcher_if.sv - selector/drain-side handshake bundle of the dispatcher
interface multi_issue_dispatcher_if #(
  parameter int NUMBER_OF_QUEUES = 4
);
  localparam int QID_W = md_pkg::qid_w(NUMBER_OF_QUEUES);

  logic                        sel_valid;
  logic [QID_W-1:0]            sel_id;
  logic [NUMBER_OF_QUEUES-1:0] empty;
  logic                        consumed;
  logic                        issue;
  logic [QID_W-1:0]            issue_id;
  logic                        retire_valid;
  logic [NUMBER_OF_QUEUES-1:0] retire_mask;

  modport master (
    output sel_valid, sel_id, empty, consumed,
    input  issue, issue_id, retire_valid, retire_mask
  );

  modport slave (
    input  sel_valid, sel_id, empty, consumed,
    output issue, issue_id, retire_valid, retire_mask
  );
endinterface

// File: rtl/multi_issue_dispatcher_id_tracker_fifo.sv
// rtl/multi_issue_dispatcher_id_tracker_fifo.sv - circular FIFO of in-flight queue IDs in issue order
module id_tracker_fifo
  import md_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              flush,
  input  logic                              push,
  input  logic [WIDTH-1:0]                  push_data,
  input  logic                              pop,
  output logic [WIDTH-1:0]                  pop_data,
  output logic [clog2_min1(DEPTH+1)-1:0]    count,
  output logic                              empty
);
  localparam int PTR_W = clog2_min1(DEPTH);
  localparam int CNT_W = clog2_min1(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST     = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign pop_ok   = pop & ~empty;
  assign push_ok  = push & (~full | pop_ok);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/multi_issue_dispatcher.sv
// rtl/multi_issue_dispatcher.sv - multi-outstanding grant dispatcher with per-queue limits, watchdog and flush
module multi_issue_dispatcher
  import md_pkg::*;
#(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int REGISTER_SIZE    = 32,
  parameter int MAX_OUTSTANDING  = 4,
  parameter int PER_QUEUE_LIMIT  = 2,
  parameter int TIMEOUT_CYCLES   = 1024,
  parameter int TIMEOUT_HALT     = 1
) (
  input  logic                               clock,
  input  logic                               reset,
  multi_issue_dispatcher_if.slave            bus,
  input  logic [REGISTER_SIZE-1:0]           epoch,
  input  logic                               err_clear,
  output logic [cnt_w(MAX_OUTSTANDING)-1:0]  outstanding,
  output logic                               timeout,
  output logic                               underflow,
  output logic                               halted
);
  localparam int QID_W = qid_w(NUMBER_OF_QUEUES);
  localparam int CNT_W = cnt_w(MAX_OUTSTANDING);
  localparam int WD_W  = clog2_min1(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] PQ_CNT  = CNT_W'(PER_QUEUE_LIMIT);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  state_t                      state;
  state_t                      state_next;
  logic                        consumed_ff;
  logic [REGISTER_SIZE-1:0]    epoch_ff;
  logic [CNT_W-1:0]            qcnt [NUMBER_OF_QUEUES];
  logic [WD_W-1:0]             wd_cnt;
  logic                        ret;
  logic                        flush_req;
  logic                        wd_hit;
  logic                        can_issue;
  logic                        do_pop;
  logic                        under_set;
  logic                        to_set;
  logic                        fifo_flush;
  logic                        epoch_load;
  logic                        wd_run;
  logic                        fifo_empty;
  logic [QID_W-1:0]            head_id;
  logic [NUMBER_OF_QUEUES-1:0] issue_mask;
  logic [NUMBER_OF_QUEUES-1:0] pop_mask;

  assign ret        = bus.consumed & ~consumed_ff;
  assign flush_req  = (epoch != epoch_ff);
  assign wd_hit     = (TIMEOUT_CYCLES != 0) && (outstanding != '0) && !ret && (wd_cnt == WD_LAST);
  assign halted     = (state == HALT);
  assign issue_mask = can_issue ? (NUMBER_OF_QUEUES'(1) << bus.sel_id) : '0;
  assign pop_mask   = do_pop ? (NUMBER_OF_QUEUES'(1) << head_id) : '0;

  id_tracker_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (QID_W)
  ) tracker (
    .clock     (clock),
    .reset     (reset),
    .flush     (fifo_flush),
    .push      (can_issue),
    .push_data (bus.sel_id),
    .pop       (do_pop),
    .pop_data  (head_id),
    .count     (outstanding),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Issue uses the pre-edge counts, so a same-cycle retire cannot open extra room.
  always_comb begin
    state_next = state;
    can_issue  = 1'b0;
    do_pop     = 1'b0;
    under_set  = 1'b0;
    to_set     = 1'b0;
    fifo_flush = 1'b0;
    epoch_load = 1'b0;
    wd_run     = 1'b0;
    case (state)
      RUN: begin
        can_issue = bus.sel_valid && !bus.empty[bus.sel_id] && (outstanding < MAX_CNT)
                    && (qcnt[bus.sel_id] < PQ_CNT) && !flush_req;
        do_pop    = ret & ~fifo_empty;
        under_set = ret & fifo_empty;
        wd_run    = 1'b1;
        if (flush_req) begin
          state_next = FLUSH;
        end else if (wd_hit) begin
          to_set = 1'b1;
          if (TIMEOUT_HALT != 0) state_next = HALT;
        end
      end
      FLUSH: begin
        fifo_flush = 1'b1;
        epoch_load = 1'b1;
        state_next = RUN;
      end
      HALT: begin
        do_pop    = ret & ~fifo_empty;
        under_set = ret & fifo_empty;
        if (err_clear) state_next = FLUSH;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || !wd_run || ret || (outstanding == '0) || wd_hit) wd_cnt <= '0;
    else                                                           wd_cnt <= wd_cnt + WD_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      consumed_ff      <= 1'b1;
      epoch_ff         <= '0;
      bus.issue        <= 1'b0;
      bus.issue_id     <= '0;
      bus.retire_valid <= 1'b0;
      bus.retire_mask  <= '0;
      timeout          <= 1'b0;
      underflow        <= 1'b0;
      for (int q = 0; q < NUMBER_OF_QUEUES; q++) qcnt[q] <= '0;
    end else begin
      consumed_ff      <= bus.consumed;
      if (epoch_load) epoch_ff <= epoch;
      bus.issue        <= can_issue;
      if (can_issue) bus.issue_id <= bus.sel_id;
      bus.retire_valid <= do_pop;
      bus.retire_mask  <= pop_mask;
      if (to_set)         timeout <= 1'b1;
      else if (err_clear) timeout <= 1'b0;
      if (under_set)      underflow <= 1'b1;
      else if (err_clear) underflow <= 1'b0;
      for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
        if (fifo_flush)                       qcnt[q] <= '0;
        else if (issue_mask[q] && !pop_mask[q]) qcnt[q] <= qcnt[q] + CNT_W'(1);
        else if (pop_mask[q] && !issue_mask[q]) qcnt[q] <= qcnt[q] - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_multi_issue_dispatcher.sv
// tb/tb_multi_issue_dispatcher.sv - directed self-checking bench for the dispatcher
module tb_multi_issue_dispatcher;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] epoch;
  logic        err_clear;
  logic [2:0]  out_a;
  logic        to_a, uf_a, h_a;
  logic [0:0]  out_b;
  logic        to_b, uf_b, h_b;
  int          checks = 0;
  int          errors = 0;

  int pipe_ids [5] = '{0, 1, 0, 1, 0};
  int pipe_iss [5] = '{1, 1, 1, 1, 0};
  int pipe_idx [5] = '{0, 1, 0, 1, 1};
  int pipe_out [5] = '{1, 2, 3, 4, 4};
  int pipe_ret [3] = '{1, 2, 1};
  int pq_iss   [4] = '{1, 1, 0, 0};
  int pq_out   [4] = '{1, 2, 2, 2};

  always #5 clock = ~clock;

  multi_issue_dispatcher_if #(.NUMBER_OF_QUEUES(4)) ia ();
  multi_issue_dispatcher_if #(.NUMBER_OF_QUEUES(4)) ib ();

  multi_issue_dispatcher #(
    .NUMBER_OF_QUEUES(4), .REGISTER_SIZE(32), .MAX_OUTSTANDING(4),
    .PER_QUEUE_LIMIT(2), .TIMEOUT_CYCLES(16), .TIMEOUT_HALT(1)
  ) dut_a (
    .clock(clock), .reset(reset), .bus(ia.slave), .epoch(epoch), .err_clear(err_clear),
    .outstanding(out_a), .timeout(to_a), .underflow(uf_a), .halted(h_a)
  );

  multi_issue_dispatcher #(
    .NUMBER_OF_QUEUES(4), .REGISTER_SIZE(32), .MAX_OUTSTANDING(1),
    .PER_QUEUE_LIMIT(1), .TIMEOUT_CYCLES(0), .TIMEOUT_HALT(1)
  ) dut_b (
    .clock(clock), .reset(reset), .bus(ib.slave), .epoch(epoch), .err_clear(err_clear),
    .outstanding(out_b), .timeout(to_b), .underflow(uf_b), .halted(h_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic toggle_a();
    ia.consumed = 1'b0;
    tick();
    ia.consumed = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b1; epoch = '0; err_clear = 1'b0;
    ia.sel_valid = 1'b0; ia.sel_id = '0; ia.empty = '1; ia.consumed = 1'b1;
    ib.sel_valid = 1'b0; ib.sel_id = '0; ib.empty = '1; ib.consumed = 1'b1;
    tick(3);
    chk("rst_issue_a", ia.issue, 0);
    chk("rst_issue_id_a", ia.issue_id, 0);
    chk("rst_retire_valid_a", ia.retire_valid, 0);
    chk("rst_retire_mask_a", ia.retire_mask, 0);
    chk("rst_outstanding_a", out_a, 0);
    chk("rst_flags_a", {to_a, uf_a, h_a}, 0);
    chk("rst_outputs_b", {ib.issue, ib.retire_valid, out_b, to_b, uf_b, h_b}, 0);

    // Consumed held high through reset release must not retire.
    reset = 1'b0;
    tick(2);
    chk("boot_no_retire", ia.retire_valid, 0);
    chk("boot_no_underflow", uf_a, 0);
    toggle_a();
    chk("underflow_set", uf_a, 1);
    chk("underflow_no_retire", ia.retire_valid, 0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("errclr_run_underflow", uf_a, 0);
    chk("errclr_run_halted", h_a, 0);

    // Legacy single-outstanding instance.
    ib.empty = '0; ib.sel_id = 2'd2; ib.sel_valid = 1'b1;
    tick();
    chk("single_issue", ib.issue, 1);
    chk("single_issue_id", ib.issue_id, 2);
    chk("single_out", out_b, 1);
    tick();
    chk("single_stall1", ib.issue, 0);
    tick(3);
    chk("single_stall2", ib.issue, 0);
    ib.consumed = 1'b0;
    tick();
    chk("single_low_no_retire", ib.retire_valid, 0);
    ib.consumed = 1'b1;
    tick();
    chk("single_retire_valid", ib.retire_valid, 1);
    chk("single_retire_mask", ib.retire_mask, 4'b0100);
    chk("single_retire_out", out_b, 0);
    chk("single_retire_no_issue", ib.issue, 0);
    tick();
    chk("single_reissue", ib.issue, 1);
    chk("single_reissue_id", ib.issue_id, 2);
    chk("single_mask_cleared", ib.retire_mask, 0);
    ib.sel_valid = 1'b0;

    // Pipelined grants up to the global limit.
    ia.empty = '0; ia.sel_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ia.sel_id = 2'(pipe_ids[i]);
      tick();
      chk($sformatf("pipe_issue%0d", i), ia.issue, pipe_iss[i]);
      chk($sformatf("pipe_id%0d", i), ia.issue_id, pipe_idx[i]);
      chk($sformatf("pipe_out%0d", i), out_a, pipe_out[i]);
    end
    ia.sel_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      toggle_a();
      chk($sformatf("pipe_rv%0d", i), ia.retire_valid, 1);
      chk($sformatf("pipe_mask%0d", i), ia.retire_mask, 4'(1 << pipe_ret[i] >> 1) | 4'(pipe_ret[i] == 2 ? 2 : 0) & 4'(pipe_ret[i] == 2 ? 2 : 1));
      chk($sformatf("pipe_rout%0d", i), out_a, 3 - i);
    end
    toggle_a();
    chk("drain_mask", ia.retire_mask, 4'b0010);
    chk("drain_out", out_a, 0);

    // Per-queue limit on queue 3.
    ia.sel_id = 2'd3; ia.sel_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("pq_issue%0d", i), ia.issue, pq_iss[i]);
      chk($sformatf("pq_out%0d", i), out_a, pq_out[i]);
    end
    ia.consumed = 1'b0;
    tick();
    chk("pq_low_no_issue", ia.issue, 0);
    ia.consumed = 1'b1;
    tick();
    chk("pq_retire_mask", ia.retire_mask, 4'b1000);
    chk("pq_retire_out", out_a, 1);
    chk("pq_retire_no_issue", ia.issue, 0);
    tick();
    chk("pq_one_more", ia.issue, 1);
    chk("pq_one_more_out", out_a, 2);
    tick();
    chk("pq_stall_again", ia.issue, 0);

    // Retire and issue on the same edge.
    ia.sel_valid = 1'b0; ia.consumed = 1'b0;
    tick();
    ia.sel_valid = 1'b1; ia.sel_id = 2'd0; ia.consumed = 1'b1;
    tick();
    chk("sim_issue", ia.issue, 1);
    chk("sim_issue_id", ia.issue_id, 0);
    chk("sim_retire_mask", ia.retire_mask, 4'b1000);
    chk("sim_out", out_a, 2);
    ia.sel_valid = 1'b0;
    toggle_a();
    chk("sim_order1", ia.retire_mask, 4'b1000);
    chk("sim_order1_out", out_a, 1);
    toggle_a();
    chk("sim_order2", ia.retire_mask, 4'b0001);
    chk("sim_order2_out", out_a, 0);

    // Watchdog trip into HALT.
    ia.sel_valid = 1'b1; ia.sel_id = 2'd2;
    tick();
    chk("wd_issue0_id", ia.issue_id, 2);
    ia.sel_id = 2'd1;
    tick();
    chk("wd_issue1", ia.issue, 1);
    chk("wd_out", out_a, 2);
    ia.sel_valid = 1'b0;
    tick(14);
    chk("wd_before_trip", {to_a, h_a}, 2'b00);
    tick();
    chk("wd_trip", {to_a, h_a}, 2'b11);
    ia.sel_valid = 1'b1; ia.sel_id = 2'd3;
    tick();
    chk("halt_no_issue", ia.issue, 0);
    toggle_a();
    chk("halt_retire_mask", ia.retire_mask, 4'b0100);
    chk("halt_retire_out", out_a, 1);
    chk("halt_still", h_a, 1);
    chk("halt_retire_no_issue", ia.issue, 0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("errclr_leaves_halt", {to_a, uf_a, h_a}, 0);
    chk("errclr_flush_pending", out_a, 1);
    tick();
    chk("flush_out", out_a, 0);
    chk("flush_no_issue", ia.issue, 0);
    tick();
    chk("resume_issue", ia.issue, 1);
    chk("resume_id", ia.issue_id, 3);
    chk("resume_out", out_a, 1);

    // Epoch-triggered flush.
    ia.sel_valid = 1'b0; epoch = 32'd5;
    tick();
    chk("ep5_edge1_out", out_a, 1);
    tick();
    chk("ep5_edge2_out", out_a, 0);
    ia.sel_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ia.sel_id = 2'(i);
      tick();
      chk($sformatf("ep_fill%0d", i), out_a, i + 1);
    end
    ia.sel_id = 2'd3; epoch = 32'd6;
    tick();
    chk("ep6_edge1_no_issue", ia.issue, 0);
    chk("ep6_edge1_out", out_a, 3);
    tick();
    chk("ep6_edge2_no_issue", ia.issue, 0);
    chk("ep6_edge2_out", out_a, 0);
    tick();
    chk("ep6_resume_issue", ia.issue, 1);
    chk("ep6_resume_out", out_a, 1);
    chk("ep6_no_halt", h_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
